// File: rtl/sort4_if.sv
// sort4_if -- handshake/data bundle between the lab operand registers and the
// sort4_ctrl sequencer.
//
// Signals:
//   start  request to sort (sampled by the sequencer only when idle)
//   din    four packed 4-bit operands, d0 = din[3:0] ... d3 = din[15:12]
//   dout   sorted result, same packing, dout[3:0] smallest
//   busy   high while a sort is in progress
//   done   one-cycle pulse when dout/swaps are updated
//   swaps  number of swaps performed in the last completed sort
//
// Modports:
//   master  the requester (drives start/din, observes results)
//   slave   the sequencer (observes start/din, drives results)
interface sort4_if;
  logic        start;
  logic [15:0] din;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic [2:0]  swaps;

  modport master (
    output start,
    output din,
    input  dout,
    input  busy,
    input  done,
    input  swaps
  );

  modport slave (
    input  start,
    input  din,
    output dout,
    output busy,
    output done,
    output swaps
  );
endinterface

// File: rtl/sort4_ctrl.sv
// sort4_ctrl -- sorts four 4-bit operands into ascending order with one shared
// magnitude comparator, performing one compare-and-swap per clock (bubble sort,
// passes of 3, 2 and 1 compares).
//
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  asynchronous, active-high reset
//   bus  sort4_if.slave: start/din in, dout/busy/done/swaps out
//
// Build option:
//   SORT4_EARLY_EXIT_EN  when defined, a pass that makes no swap ends the sort
//                        immediately (already-sorted data finishes after one
//                        pass). When undefined, every sort takes six compares.
module sort4_ctrl (
  input  logic     clk,
  input  logic     rst,
  sort4_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  r [4];
  logic [1:0]  pass;
  logic [1:0]  idx;
  logic [2:0]  swap_cnt;
  logic        pass_flag;

  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic [1:0]  cmp_res;
  logic        do_swap;
  logic        flag_next;
  logic [1:0]  last_idx;

  // Shared comparator: 01 = a>b, 10 = a<b, 00 = equal. Only a strict "a>b"
  // swaps, so equal elements keep their order.
  always_comb begin
    op_a      = r[idx];
    op_b      = r[idx + 2'd1];
    cmp_res   = 2'b00;
    if (op_a > op_b)
      cmp_res = 2'b01;
    else if (op_a < op_b)
      cmp_res = 2'b10;
    do_swap   = (cmp_res == 2'b01);
    flag_next = pass_flag | do_swap;
    last_idx  = 2'd2 - pass;
  end

  // Sequencer: latch operands, walk the compare-and-swap schedule, then publish
  // the result for one cycle. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++)
        r[i] <= 4'h0;
      pass      <= 2'd0;
      idx       <= 2'd0;
      swap_cnt  <= 3'd0;
      pass_flag <= 1'b0;
      bus.dout  <= 16'h0000;
      bus.swaps <= 3'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            r[0]      <= bus.din[3:0];
            r[1]      <= bus.din[7:4];
            r[2]      <= bus.din[11:8];
            r[3]      <= bus.din[15:12];
            pass      <= 2'd0;
            idx       <= 2'd0;
            swap_cnt  <= 3'd0;
            pass_flag <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= CMP;
          end
        end

        CMP: begin
          if (do_swap) begin
            r[idx]         <= op_b;
            r[idx + 2'd1]  <= op_a;
            swap_cnt       <= swap_cnt + 3'd1;
          end
          if (idx == last_idx) begin
            // End of a pass: the flag includes this compare's swap.
            idx       <= 2'd0;
            pass      <= pass + 2'd1;
            pass_flag <= 1'b0;
            if (pass == 2'd2)
              state <= DONE;
`ifdef SORT4_EARLY_EXIT_EN
            else if (!flag_next)
              state <= DONE;
`else
            else
              state <= CMP;
`endif
          end else begin
            idx       <= idx + 2'd1;
            pass_flag <= flag_next;
          end
        end

        DONE: begin
          bus.dout  <= {r[3], r[2], r[1], r[0]};
          bus.swaps <= swap_cnt;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
